// File: rtl/arb_types.sv
// Shared types for the memory line-port arbiter.
//   arb_state_t : arbiter FSM state
//   grant_t     : which cache received the most recent grant (round-robin memory)
package arb_types;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one physical-memory line port between the instruction cache (I) and
// the data cache (D). One line transaction is granted at a time. The grantee's
// command, aligned address and write line are latched at grant and drive the
// memory side for the whole transaction. Simultaneous requests are resolved
// round-robin against the previous grantee.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_read, i_addr           I-cache line read request (held until i_resp)
//   i_rdata, i_resp          I-cache return line and one-cycle completion pulse
//   d_read, d_write, d_addr  D-cache read / writeback request (held until d_resp)
//   d_wdata                  D-cache writeback line
//   d_rdata, d_resp          D-cache return line and one-cycle completion pulse
//   mem_read, mem_write      line command to the cacheline adaptor
//   mem_addr, mem_wdata      line-aligned address and write line to the adaptor
//   mem_rdata, mem_resp      adaptor return line and one-cycle completion
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; arbitrate, latch grantee command on grant
// SERVE_I | I-cache line read in flight; wait for mem_resp
// SERVE_D | D-cache read or writeback in flight; wait for mem_resp
module mem_port_arbiter
    import arb_types::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    // Clears the line-offset bits so the adaptor always sees a line address.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;

    arb_state_t        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic              cmd_rd_q, cmd_rd_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic i_req;
    logic d_req;
    logic pick_d;

    assign i_req  = i_read;
    assign d_req  = d_read | d_write;
    // D wins when it is alone, or on a tie when I was granted last.
    assign pick_d = d_req & (~i_req | (last_grant_q == GRANT_I));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_rd_d     = cmd_rd_q;
        cmd_wr_d     = cmd_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d      = SERVE_D;
                    last_grant_d = GRANT_D;
                    // A simultaneous read+write from D is resolved as a write.
                    cmd_wr_d     = d_write;
                    cmd_rd_d     = d_read & ~d_write;
                    addr_d       = d_addr & ALIGN_MASK;
                    wdata_d      = d_wdata;
                end else if (i_req) begin
                    state_d      = SERVE_I;
                    last_grant_d = GRANT_I;
                    cmd_rd_d     = 1'b1;
                    cmd_wr_d     = 1'b0;
                    addr_d       = i_addr & ALIGN_MASK;
                    wdata_d      = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                // Returning to IDLE forces one idle cycle between transactions,
                // giving the finished requester time to drop its request.
                if (mem_resp) begin
                    state_d  = IDLE;
                    cmd_rd_d = 1'b0;
                    cmd_wr_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                cmd_rd_d = 1'b0;
                cmd_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            cmd_rd_q     <= 1'b0;
            cmd_wr_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_rd_q     <= cmd_rd_d;
            cmd_wr_q     <= cmd_wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign mem_read  = cmd_rd_q;
    assign mem_write = cmd_wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Completion is passed straight through in the mem_resp cycle; a
    // mem_resp seen in IDLE matches neither state and is dropped.
    assign i_resp  = (state_q == SERVE_I) & mem_resp;
    assign d_resp  = (state_q == SERVE_D) & mem_resp;
    assign i_rdata = i_resp ? mem_rdata : '0;
    assign d_rdata = d_resp ? mem_rdata : '0;

endmodule
